rv_trace_buffer: RTL and testbench
==================================

# rv_trace_buffer

Synthesizable post-trigger trace capture buffer for the pipelined RV32I core. It samples one pipeline stage per valid cycle (PC, instruction, exception flag, typically from ID/EX) into a circular buffer of configurable depth. On a programmable trigger it records a fixed number of post-trigger samples, then freezes so the bench or a debug port can read the history back oldest-first.

## Interface
- `XLEN`, 32: PC width.
- `DEPTH`, 16: buffer entries; power of two, ≥2.
- `POST_SAMPLES`, 4: samples captured after the trigger sample; 0 ≤ value < DEPTH.
- `TS_W`, 16: timestamp width (used only with `TRACE_TIMESTAMP_EN`).

Ports:
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `trc_valid`  in  1  sample qualifier.
- `trc_pc`  in  XLEN  sampled PC.
- `trc_instr`  in  32  sampled instruction.
- `trc_exc`  in  1  sampled exception flag.
- `arm`  in  1  single-cycle pulse; clears the buffer and starts capture.
- `trig_mode`  in  2  0 = exception, 1 = PC match, 2 = exception or PC match, 3 = never (free-run).
- `trig_pc`  in  XLEN  PC match value.
- `rd_en`  in  1  read request.
- `rd_idx`  in  log2(DEPTH)  entry index relative to the oldest entry.
- `rd_data`  out  ENTRY_W  entry = {[ts,] exc, trig, instr, pc}; ENTRY_W = XLEN+34 (+TS_W).
- `rd_valid`  out  1  `rd_data` valid.
- `trc_state`  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- `trc_count`  out  log2(DEPTH)+1  number of stored entries, saturates at DEPTH.
- `trig_pos`  out  log2(DEPTH)  index of the trigger entry relative to the oldest entry; 0 unless DONE.

## Operation
- **Reset:** state IDLE. Write pointer, count, trigger pointer, post counter, `rd_data`, `rd_valid` and the timestamp counter are all 0. Buffer RAM contents are undefined.
- **IDLE:** samples are ignored. An `arm` pulse moves to ARMED and clears the write pointer and count.
- **ARMED:** each `trc_valid` writes one entry at the write pointer.
  - Write pointer advances modulo DEPTH; count saturates at DEPTH, after which the oldest entry is overwritten.
  - Trigger condition is evaluated on the same valid sample. Exception: `trc_exc`=1. PC match: `trc_pc`==`trig_pc`. Mode 3 never triggers.
  - The triggering sample is stored with `trig`=1 and its physical address is latched.
  - On trigger, go to POST with post counter = POST_SAMPLES, or go straight to DONE if POST_SAMPLES==0.
- **POST:** each valid sample is written and decrements the post counter. The write that brings it to 0 also moves to DONE. Further trigger conditions are recorded in the `exc` field only and do not retrigger.
- **DONE:** no writes. The buffer holds until the next `arm`.
- **`arm` in any state:** restarts ARMED with count 0. When `arm` and `trc_valid` arrive in the same cycle, `arm` wins and the sample is discarded.
- **Read:**
  - Allowed in every state; contents are only coherent in DONE.
  - Physical address = (count==DEPTH ? write pointer : 0) + `rd_idx`, modulo DEPTH.
  - If `rd_idx` ≥ count, `rd_data`=0.
- **`trig_pos`:** (trigger pointer − oldest physical address) mod DEPTH.

## Timing
- A sample is written on the rising edge where `trc_valid`=1, and the state transition happens on that same edge. `trc_state` and `trc_count` reflect it in the next cycle.
- Read latency is 1 cycle: `rd_en` at edge N gives `rd_data` and `rd_valid`=1 after edge N. `rd_valid` is high for exactly one cycle per request. Back-to-back reads are allowed every cycle.
- `rd_valid` and `rd_data` hold their previous values while `rd_en`=0, except that `rd_valid` clears.
- Asserting `reset_n` low mid-operation (any state, including POST) forces reset values immediately, without waiting for a clock.

## Configuration
- `TRACE_TIMESTAMP_EN` defined:
  - A TS_W-bit cycle counter runs freely from reset and wraps at 2^TS_W.
  - Its value at the write edge is stored in the top TS_W bits of each entry; ENTRY_W = XLEN+34+TS_W.
  - `arm` does not clear the counter.
- Undefined: no counter, ENTRY_W = XLEN+34, and all other behaviour is identical.

## Test plan
- **Reset/idle:** reset, then 5 valid samples with no `arm` → `trc_state`=0, `trc_count`=0, `rd_valid`=0.
- **Exception trigger:** DEPTH=16, POST=4, mode 0; `arm`, then 20 samples with pc=4k, `trc_exc`=1 on the 10th (pc 0x24).
  - DONE after the 14th sample; `trc_count`=14, `trig_pos`=9.
  - `rd_idx`=9 → pc 0x24, exc=1, trig=1.
  - Samples 15–20 are not stored.
- **Wrap:** mode 1, `trig_pc`=0x100, samples pc=4k for k=0..80.
  - `trc_count`=16, `trig_pos`=11.
  - `rd_idx`=0 → pc 0xD4; `rd_idx`=15 → pc 0x110.
- **Collisions:**
  - `arm` coincident with a triggering sample → state ARMED, count 0.
  - `arm` during POST → state ARMED, count 0.
- **Free-run and async reset:**
  - Mode 3 with 40 samples → stays ARMED, count 16.
  - `reset_n` low mid-POST → IDLE and count 0 before the next edge.
- **Timestamp (with `TRACE_TIMESTAMP_EN`):** samples at cycles 100 and 103 read back with ts fields differing by 3; wrap at 2^TS_W is verified.

Source files
------------

// File: rtl/rv_trace_buffer_if.sv
// Trace sample and readback bundle for rv_trace_buffer.
// master: sample source / debug reader (drives trc_*, rd_en, rd_idx; sees rd_data, rd_valid).
// slave : the trace buffer itself.
// ENTRY_W grows by TS_W when TRACE_TIMESTAMP_EN is defined.
interface rv_trace_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
);
  localparam int AW = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int ENTRY_W = XLEN + 34 + (TS_EN ? TS_W : 0);

  // sample side
  logic               trc_valid;
  logic [XLEN-1:0]    trc_pc;
  logic [31:0]        trc_instr;
  logic               trc_exc;
  // readback side
  logic               rd_en;
  logic [AW-1:0]      rd_idx;
  logic [ENTRY_W-1:0] rd_data;
  logic               rd_valid;

  modport master (
    output trc_valid, trc_pc, trc_instr, trc_exc, rd_en, rd_idx,
    input  rd_data, rd_valid
  );

  modport slave (
    input  trc_valid, trc_pc, trc_instr, trc_exc, rd_en, rd_idx,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/rv_trace_buffer.sv
// Post-trigger trace capture buffer for the RV32I pipeline (PC, instr, exc per valid cycle).
// Latency: sample written on the qualifying edge; readback has 1-cycle latency.
// Backpressure: none; the sampler never stalls, the buffer freezes once DONE.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   trc (slave modport) trc_valid/trc_pc/trc_instr/trc_exc samples, rd_en/rd_idx -> rd_data/rd_valid
//   arm                 one-cycle pulse: clear buffer and (re)start capture
//   trig_mode, trig_pc  0 exc, 1 pc match, 2 either, 3 never
//   trc_state           0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   trc_count           stored entries, saturates at DEPTH
//   trig_pos            trigger entry index relative to oldest, 0 unless DONE
// Optional feature macro: TRACE_TIMESTAMP_EN (adds a free-running TS_W-bit timestamp
// in the top bits of every entry).
module rv_trace_buffer #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 16,
  parameter int POST_SAMPLES = 4,
  parameter int TS_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  rv_trace_buffer_if.slave         trc,
  input  logic                     arm,
  input  logic [1:0]               trig_mode,
  input  logic [XLEN-1:0]          trig_pc,
  output logic [1:0]               trc_state,
  output logic [$clog2(DEPTH):0]   trc_count,
  output logic [$clog2(DEPTH)-1:0] trig_pos
);

  localparam int AW = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int ENTRY_W = XLEN + 34 + (TS_EN ? TS_W : 0);

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_LD = AW'(POST_SAMPLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [AW-1:0]       wr_ptr;
  logic [AW:0]         count;
  logic [AW-1:0]       trig_ptr;
  logic [AW-1:0]       post_cnt;

  logic                pc_match;
  logic                trig_hit;
  logic                wr_en;
  logic                trig_fire;
  logic [ENTRY_W-1:0]  wr_entry;

  logic [AW-1:0]       oldest;
  logic [AW-1:0]       rd_addr;
  logic                rd_hit;

  logic [ENTRY_W-1:0]  mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Trigger decode
  // ---------------------------------------------------------------------------
  assign pc_match = (trc.trc_pc == trig_pc);

  always_comb begin
    trig_hit = 1'b0;
    unique case (trig_mode)
      2'd0:    trig_hit = trc.trc_exc;
      2'd1:    trig_hit = pc_match;
      2'd2:    trig_hit = trc.trc_exc | pc_match;
      default: trig_hit = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // arm takes priority over any sample in the same cycle; that sample is dropped.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    trig_fire = 1'b0;
    if (arm) begin
      state_nxt = ST_ARMED;
    end else begin
      unique case (state)
        ST_ARMED: begin
          if (trc.trc_valid) begin
            wr_en = 1'b1;
            if (trig_hit) begin
              trig_fire = 1'b1;
              state_nxt = (POST_SAMPLES == 0) ? ST_DONE : ST_POST;
            end
          end
        end
        ST_POST: begin
          if (trc.trc_valid) begin
            wr_en = 1'b1;
            // The write that takes the counter from 1 to 0 is the last one.
            if (post_cnt == AW'(1)) begin
              state_nxt = ST_DONE;
            end
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      count    <= '0;
      trig_ptr <= '0;
      post_cnt <= '0;
    end else if (arm) begin
      wr_ptr   <= '0;
      count    <= '0;
      trig_ptr <= '0;
      post_cnt <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (count != FULL) begin
        count <= count + (AW+1)'(1);
      end
      if (trig_fire) begin
        trig_ptr <= wr_ptr;
        post_cnt <= POST_LD;
      end else if (state == ST_POST) begin
        post_cnt <= post_cnt - AW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional timestamp and entry packing
  // ---------------------------------------------------------------------------
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  // Free-running; arm deliberately leaves it alone so timestamps stay
  // comparable across captures.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end

  assign wr_entry = {ts_cnt, trc.trc_exc, trig_fire, trc.trc_instr, trc.trc_pc};
`else
  assign wr_entry = {trc.trc_exc, trig_fire, trc.trc_instr, trc.trc_pc};
`endif

  // Trace RAM: no reset, contents are only meaningful below trc_count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Readback, indexed from the oldest entry
  // ---------------------------------------------------------------------------
  // Until the buffer has wrapped the oldest entry sits at address 0; after
  // that it is the slot the write pointer is about to overwrite.
  assign oldest  = (count == FULL) ? wr_ptr : '0;
  assign rd_addr = oldest + trc.rd_idx;
  assign rd_hit  = ({1'b0, trc.rd_idx} < count);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trc.rd_data  <= '0;
      trc.rd_valid <= 1'b0;
    end else begin
      trc.rd_valid <= trc.rd_en;
      if (trc.rd_en) begin
        trc.rd_data <= rd_hit ? mem[rd_addr] : '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign trc_state = state;
  assign trc_count = count;
  assign trig_pos  = (state == ST_DONE) ? (trig_ptr - oldest) : '0;

endmodule

// File: tb/tb_rv_trace_buffer.sv
// Self-checking bench for rv_trace_buffer: queue-based reference model of the
// stored history, read requests push expected entries to a scoreboard that is
// popped when rd_valid comes back.
module tb_rv_trace_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int POST  = 4;
  localparam int TS_W  = 8;
  localparam int AW    = 4;
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = XLEN + 34 + TS_W;
`else
  localparam int ENTRY_W = XLEN + 34;
`endif

  typedef logic [ENTRY_W-1:0] entry_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            arm = 1'b0;
  logic [1:0]      trig_mode = 2'd0;
  logic [XLEN-1:0] trig_pc = '0;
  logic [1:0]      trc_state;
  logic [AW:0]     trc_count;
  logic [AW-1:0]   trig_pos;

  rv_trace_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH), .TS_W(TS_W)) bus ();

  rv_trace_buffer #(
    .XLEN(XLEN), .DEPTH(DEPTH), .POST_SAMPLES(POST), .TS_W(TS_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .trc       (bus),
    .arm       (arm),
    .trig_mode (trig_mode),
    .trig_pc   (trig_pc),
    .trc_state (trc_state),
    .trc_count (trc_count),
    .trig_pos  (trig_pos)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: m_q holds stored entries oldest-first.
  entry_t m_q[$];
  entry_t exp_q[$];
  int     m_state = 0;
  int     m_post = 0;

  function automatic entry_t mk_entry(logic exc, logic trig, logic [31:0] instr, logic [31:0] pc);
    entry_t e;
    e = '0;
    e[XLEN-1:0]       = pc;
    e[XLEN+31:XLEN]   = instr;
    e[XLEN+32]        = trig;
    e[XLEN+33]        = exc;
`ifdef TRACE_TIMESTAMP_EN
    e[ENTRY_W-1 -: TS_W] = TS_W'(cyc);
`endif
    return e;
  endfunction

  function automatic void m_arm();
    m_state = 1;
    m_post  = 0;
    m_q.delete();
  endfunction

  function automatic void m_write(logic [31:0] pc, logic [31:0] instr, logic exc);
    logic hit;
    int   st;
    st = m_state;
    case (trig_mode)
      2'd0:    hit = exc;
      2'd1:    hit = (pc == trig_pc);
      2'd2:    hit = exc || (pc == trig_pc);
      default: hit = 1'b0;
    endcase
    if (st == 1 || st == 2) begin
      if (m_q.size() == DEPTH) void'(m_q.pop_front());
      m_q.push_back(mk_entry(exc, (st == 1) && hit, instr, pc));
      if (st == 1 && hit) begin
        if (POST == 0) m_state = 3;
        else begin
          m_state = 2;
          m_post  = POST;
        end
      end else if (st == 2) begin
        m_post--;
        if (m_post == 0) m_state = 3;
      end
    end
  endfunction

  function automatic entry_t m_exp(int idx);
    return (idx < m_q.size()) ? m_q[idx] : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic sample(input logic [31:0] pc, input logic exc);
    bus.trc_valid = 1'b1;
    bus.trc_pc    = pc;
    bus.trc_instr = {pc[15:0], 16'h0013};
    bus.trc_exc   = exc;
    if (!arm) m_write(pc, {pc[15:0], 16'h0013}, exc);
    tick();
    bus.trc_valid = 1'b0;
    bus.trc_exc   = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    m_arm();
    tick();
    arm = 1'b0;
  endtask

  // Issues one read and records the expected entry; the caller compares.
  task automatic rd_req(input int idx);
    bus.rd_en  = 1'b1;
    bus.rd_idx = AW'(idx);
    exp_q.push_back(m_exp(idx));
    tick();
    bus.rd_en  = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    entry_t e;
    #3;
    checks++;
    if (trc_state !== 2'd0 || trc_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d count=%0d, required 0/0", trc_state, trc_count);
    end
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0 || trig_pos !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: rd_valid=%0b rd_data=%h trig_pos=%0d, required 0", bus.rd_valid, bus.rd_data, trig_pos);
    end
    tick();
    tick();
    reset_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 5; k++) sample(32'h40 + 32'(4 * k), 1'b1);
    checks++;
    if (trc_state !== 2'd0 || trc_count !== 5'd0 || bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: state=%0d count=%0d rd_valid=%0b, required 0/0/0", trc_state, trc_count, bus.rd_valid);
    end
    rd_req(0);
    e = exp_q.pop_front();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
      errors++;
      $display("FAIL idle_read: rd_valid=%0b rd_data=%h, required 1/%h", bus.rd_valid, bus.rd_data, e);
    end
  endtask

  task automatic test_exc_trigger();
    entry_t e;
    trig_mode = 2'd0;
    do_arm();
    checks++;
    if (trc_state !== 2'd1 || trc_count !== 5'd0) begin
      errors++;
      $display("FAIL exc_armed: state=%0d count=%0d, required 1/0", trc_state, trc_count);
    end
    for (int k = 0; k < 20; k++) begin
      sample(32'(4 * k), k == 9);
      if (k == 12) begin
        checks++;
        if (trc_state !== 2'd2) begin
          errors++;
          $display("FAIL exc_post_13: state=%0d, required 2", trc_state);
        end
      end
      if (k == 13) begin
        checks++;
        if (trc_state !== 2'd3) begin
          errors++;
          $display("FAIL exc_done_14: state=%0d, required 3", trc_state);
        end
      end
    end
    checks++;
    if (trc_state !== 2'd3 || trc_count !== 5'd14 || trig_pos !== 4'd9) begin
      errors++;
      $display("FAIL exc_final: state=%0d count=%0d trig_pos=%0d, required 3/14/9", trc_state, trc_count, trig_pos);
    end
    rd_req(9);
    e = exp_q.pop_front();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
      errors++;
      $display("FAIL exc_rd9: rd_valid=%0b rd_data=%h, required 1/%h", bus.rd_valid, bus.rd_data, e);
    end
    checks++;
    if (bus.rd_data[XLEN-1:0] !== 32'h24 || bus.rd_data[XLEN+33] !== 1'b1 || bus.rd_data[XLEN+32] !== 1'b1) begin
      errors++;
      $display("FAIL exc_rd9_fields: pc=%h exc=%0b trig=%0b, required 24/1/1",
               bus.rd_data[XLEN-1:0], bus.rd_data[XLEN+33], bus.rd_data[XLEN+32]);
    end
    rd_req(14);
    e = exp_q.pop_front();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== e || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL exc_rd14_empty: rd_data=%h, required 0", bus.rd_data);
    end
  endtask

  task automatic test_wrap();
    entry_t e;
    trig_mode = 2'd1;
    trig_pc   = 32'h100;
    do_arm();
    for (int k = 0; k <= 80; k++) sample(32'(4 * k), 1'b0);
    checks++;
    if (trc_state !== 2'd3 || trc_count !== 5'd16 || trig_pos !== 4'd11) begin
      errors++;
      $display("FAIL wrap_final: state=%0d count=%0d trig_pos=%0d, required 3/16/11", trc_state, trc_count, trig_pos);
    end
    rd_req(0);
    e = exp_q.pop_front();
    checks++;
    if (bus.rd_data !== e || bus.rd_data[XLEN-1:0] !== 32'hD4) begin
      errors++;
      $display("FAIL wrap_rd0: rd_data=%h, required %h (pc D4)", bus.rd_data, e);
    end
    rd_req(15);
    e = exp_q.pop_front();
    checks++;
    if (bus.rd_data !== e || bus.rd_data[XLEN-1:0] !== 32'h110) begin
      errors++;
      $display("FAIL wrap_rd15: rd_data=%h, required %h (pc 110)", bus.rd_data, e);
    end
    rd_req(11);
    e = exp_q.pop_front();
    checks++;
    if (bus.rd_data !== e || bus.rd_data[XLEN-1:0] !== 32'h100 || bus.rd_data[XLEN+32] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_rd11_trig: rd_data=%h, required %h (pc 100 trig 1)", bus.rd_data, e);
    end
  endtask

  task automatic test_back_to_back();
    entry_t e;
    e = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_en  = 1'b1;
      bus.rd_idx = AW'(i);
      exp_q.push_back(m_exp(i));
      tick();
      checks++;
      if (bus.rd_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: rd_valid=%0b, required 1", i, bus.rd_valid);
      end else begin
        e = exp_q.pop_front();
        if (bus.rd_data !== e) begin
          errors++;
          $display("FAIL b2b_data[%0d]: rd_data=%h, required %h", i, bus.rd_data, e);
        end
      end
    end
    bus.rd_en = 1'b0;
    bus.rd_idx = '0;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== e) begin
      errors++;
      $display("FAIL b2b_hold: rd_valid=%0b rd_data=%h, required 0/%h", bus.rd_valid, bus.rd_data, e);
    end
  endtask

  task automatic test_collisions();
    trig_mode = 2'd0;
    do_arm();
    for (int k = 0; k < 3; k++) sample(32'h200 + 32'(4 * k), 1'b0);
    arm = 1'b1;
    m_arm();
    sample(32'h300, 1'b1);
    arm = 1'b0;
    checks++;
    if (trc_state !== 2'd1 || trc_count !== 5'd0) begin
      errors++;
      $display("FAIL coll_arm_trig: state=%0d count=%0d, required 1/0", trc_state, trc_count);
    end
    sample(32'h304, 1'b1);
    sample(32'h308, 1'b0);
    checks++;
    if (trc_state !== 2'd2 || trc_count !== 5'd2) begin
      errors++;
      $display("FAIL coll_post: state=%0d count=%0d, required 2/2", trc_state, trc_count);
    end
    do_arm();
    checks++;
    if (trc_state !== 2'd1 || trc_count !== 5'd0) begin
      errors++;
      $display("FAIL coll_arm_post: state=%0d count=%0d, required 1/0", trc_state, trc_count);
    end
  endtask

  task automatic test_free_run();
    entry_t e;
    trig_mode = 2'd3;
    do_arm();
    for (int k = 0; k < 40; k++) sample(32'(4 * k), (k % 5) == 0);
    checks++;
    if (trc_state !== 2'd1 || trc_count !== 5'd16 || trig_pos !== 4'd0) begin
      errors++;
      $display("FAIL free_run: state=%0d count=%0d trig_pos=%0d, required 1/16/0", trc_state, trc_count, trig_pos);
    end
    rd_req(0);
    e = exp_q.pop_front();
    checks++;
    if (bus.rd_data !== e || bus.rd_data[XLEN-1:0] !== 32'h60) begin
      errors++;
      $display("FAIL free_run_rd0: rd_data=%h, required %h (pc 60)", bus.rd_data, e);
    end
  endtask

  task automatic test_async_reset();
    entry_t e;
    trig_mode = 2'd0;
    do_arm();
    sample(32'h500, 1'b1);
    checks++;
    if (trc_state !== 2'd2) begin
      errors++;
      $display("FAIL async_pre_post: state=%0d, required 2", trc_state);
    end
    rd_req(0);
    e = exp_q.pop_front();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
      errors++;
      $display("FAIL async_pre_read: rd_valid=%0b rd_data=%h, required 1/%h", bus.rd_valid, bus.rd_data, e);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (trc_state !== 2'd0 || trc_count !== 5'd0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL async_reset: state=%0d count=%0d rd_valid=%0b rd_data=%h, required 0/0/0/0",
               trc_state, trc_count, bus.rd_valid, bus.rd_data);
    end
    tick();
    reset_n = 1'b1;
    cyc = 0;
    m_state = 0;
    m_q.delete();
    tick();
    checks++;
    if (trc_state !== 2'd0 || trc_count !== 5'd0) begin
      errors++;
      $display("FAIL async_after: state=%0d count=%0d, required 0/0", trc_state, trc_count);
    end
  endtask

`ifdef TRACE_TIMESTAMP_EN
  task automatic test_timestamp();
    entry_t e;
    logic [TS_W-1:0] ts0;
    logic [TS_W-1:0] ts1;
    trig_mode = 2'd3;
    do_arm();
    while (cyc < 100) tick();
    sample(32'h600, 1'b0);
    tick();
    tick();
    sample(32'h604, 1'b0);
    while (cyc < 300) tick();
    sample(32'h608, 1'b0);
    rd_req(0);
    e = exp_q.pop_front();
    ts0 = bus.rd_data[ENTRY_W-1 -: TS_W];
    checks++;
    if (bus.rd_data !== e || ts0 !== 8'd100) begin
      errors++;
      $display("FAIL ts_first: rd_data=%h ts=%0d, required %h ts 100", bus.rd_data, ts0, e);
    end
    rd_req(1);
    e = exp_q.pop_front();
    ts1 = bus.rd_data[ENTRY_W-1 -: TS_W];
    checks++;
    if (bus.rd_data !== e || (ts1 - ts0) !== 8'd3) begin
      errors++;
      $display("FAIL ts_delta: ts1=%0d ts0=%0d, required difference 3", ts1, ts0);
    end
    rd_req(2);
    e = exp_q.pop_front();
    checks++;
    if (bus.rd_data !== e || bus.rd_data[ENTRY_W-1 -: TS_W] !== 8'd44) begin
      errors++;
      $display("FAIL ts_wrap: rd_data=%h ts=%0d, required %h ts 44", bus.rd_data, bus.rd_data[ENTRY_W-1 -: TS_W], e);
    end
  endtask
`endif

  initial begin
    bus.trc_valid = 1'b0;
    bus.trc_pc    = '0;
    bus.trc_instr = '0;
    bus.trc_exc   = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_idx    = '0;
    test_reset();
    test_exc_trigger();
    test_wrap();
    test_back_to_back();
    test_collisions();
    test_free_run();
    test_async_reset();
`ifdef TRACE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
